bus_memory_responder: RTL and testbench



---
 rtl/bus_memory_responder_if.sv | 33 +++
 rtl/bus_memory_responder.sv | 173 +++++++++++++++++
 tb/tb_bus_memory_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_memory_responder_if.sv
// Cache bus request/response channel between the L1 cache (master) and
// the backing-store memory responder (slave).
//   bus_reqcyc  : request beat valid, held until acknowledged
//   bus_req     : address (first beat) or write data (later beats)
//   bus_reqtag  : request tag, meaningful on the address beat
//   bus_reqack  : one-cycle acceptance pulse per request beat
//   bus_respcyc : response beat valid
//   bus_resp    : response data beat
//   bus_resptag : echo of the accepted read tag
//   bus_respack : requester consumes the current response beat
interface bus_memory_responder_if #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/bus_memory_responder.sv
// Memory-side responder of the cache bus. Accepts line reads and line
// writes, returns lines as LINE_BEATS beats in critical-word-first
// wrap-around order after a fixed READ_LATENCY.
//   clk   : clock
//   reset : synchronous, active-low reset (memory contents are kept)
//   bus   : request/response channel (slave side)
//   busy  : high whenever the responder is not idle
module bus_memory_responder #(
    parameter int unsigned              BUS_DATA_WIDTH = 64,
    parameter int unsigned              BUS_TAG_WIDTH  = 13,
    parameter int unsigned              LINE_BEATS     = 8,
    parameter int unsigned              MEM_WORDS      = 4096,
    parameter int unsigned              READ_LATENCY   = 4,
    parameter logic [BUS_TAG_WIDTH-1:0] TAG_READ       = 13'h1100,
    parameter logic [BUS_TAG_WIDTH-1:0] TAG_WRITE      = 13'h1000
) (
    input  logic                         clk,
    input  logic                         reset,
    bus_memory_responder_if.slave        bus,
    output logic                         busy
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned BW = $clog2(LINE_BEATS);
    localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
    localparam logic [CW-1:0] LAT_INIT  = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE_DATA,
        S_READ_WAIT,
        S_READ_RESP
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [AW-BW-1:0]          r_line;
    logic [BW-1:0]             r_sb;
    logic [BW-1:0]             r_beat;
    logic [CW-1:0]             r_lat;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic                      r_reqack;
    logic                      r_respcyc;
    logic [BUS_DATA_WIDTH-1:0] r_resp;
    logic [BUS_TAG_WIDTH-1:0]  r_resptag;
    logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic [AW-1:0]             w_idx;
    logic                      w_accept;
    logic [BW-1:0]             w_beat_nxt;
    logic [BW-1:0]             w_wr_off;
    logic [BW-1:0]             w_rd_off;
    logic [AW-1:0]             w_wr_addr;
    logic [AW-1:0]             w_rd_addr;
    logic                      w_mem_we;

    // A beat is taken only when the previous cycle did not already ack,
    // which limits acceptance to one beat per two cycles.
    always_comb begin
        w_idx      = bus.bus_req[3 +: AW];
        w_accept   = bus.bus_reqcyc && !r_reqack &&
                     (r_state == S_IDLE || r_state == S_WRITE_DATA);
        w_beat_nxt = r_beat + BW'(1);
        w_wr_off   = r_sb + r_beat;
        // READ_WAIT fetches beat 0; READ_RESP prefetches the following beat.
        w_rd_off   = (r_state == S_READ_RESP) ? (r_sb + w_beat_nxt) : r_sb;
        w_wr_addr  = {r_line, w_wr_off};
        w_rd_addr  = {r_line, w_rd_off};
        w_mem_we   = reset && (r_state == S_WRITE_DATA) && w_accept;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.bus_reqtag == TAG_READ)
                        w_next_state = S_READ_WAIT;
                    else if (bus.bus_reqtag == TAG_WRITE)
                        w_next_state = S_WRITE_DATA;
                end
            end
            S_WRITE_DATA: begin
                if (w_accept && r_beat == LAST_BEAT)
                    w_next_state = S_IDLE;
            end
            S_READ_WAIT: begin
                if (r_lat == '0)
                    w_next_state = S_READ_RESP;
            end
            S_READ_RESP: begin
                if (bus.bus_respack && r_beat == LAST_BEAT)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_line    <= '0;
            r_sb      <= '0;
            r_beat    <= '0;
            r_lat     <= '0;
            r_tag     <= '0;
            r_reqack  <= 1'b0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
            r_resptag <= '0;
        end else begin
            r_reqack <= w_accept;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_line <= w_idx[AW-1:BW];
                        r_sb   <= w_idx[BW-1:0];
                        r_tag  <= bus.bus_reqtag;
                        r_lat  <= LAT_INIT;
                        r_beat <= '0;
                    end
                end
                S_WRITE_DATA: begin
                    if (w_accept)
                        r_beat <= w_beat_nxt;
                end
                S_READ_WAIT: begin
                    if (r_lat == '0) begin
                        r_respcyc <= 1'b1;
                        r_resp    <= r_mem[w_rd_addr];
                        r_resptag <= r_tag;
                    end else begin
                        r_lat <= r_lat - CW'(1);
                    end
                end
                S_READ_RESP: begin
                    if (bus.bus_respack) begin
                        if (r_beat == LAST_BEAT) begin
                            r_respcyc <= 1'b0;
                            r_resp    <= '0;
                            r_resptag <= '0;
                            r_beat    <= '0;
                        end else begin
                            r_beat <= w_beat_nxt;
                            r_resp <= r_mem[w_rd_addr];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Backing store has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_wr_addr] <= bus.bus_req;
    end

    always_comb begin
        bus.bus_reqack  = r_reqack;
        bus.bus_respcyc = r_respcyc;
        bus.bus_resp    = r_resp;
        bus.bus_resptag = r_resptag;
        busy            = (r_state != S_IDLE);
    end
endmodule

// File: tb/tb_bus_memory_responder.sv
// Self-checking bench for bus_memory_responder: directed line write,
// table of reads, back-pressure, busy rejection, reset mid-read, unknown
// tag, then random writes/reads checked against a word-array model.
module tb_bus_memory_responder;
    localparam int unsigned DW        = 64;
    localparam int unsigned TW        = 13;
    localparam int unsigned LB        = 8;
    localparam int unsigned MW        = 4096;
    localparam int unsigned RL        = 4;
    localparam int unsigned AW        = 12;
    localparam logic [TW-1:0] TAG_RD  = 13'h1100;
    localparam logic [TW-1:0] TAG_WR  = 13'h1000;

    logic clk;
    logic reset;
    logic busy;

    bus_memory_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

    bus_memory_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH(TW),
        .LINE_BEATS(LB),
        .MEM_WORDS(MW),
        .READ_LATENCY(RL),
        .TAG_READ(TAG_RD),
        .TAG_WRITE(TAG_WR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int ack_pulses = 0;
    int resp_beats = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.bus_reqack)  ack_pulses <= ack_pulses + 1;
        if (bus.bus_respcyc) resp_beats <= resp_beats + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int ack_cyc  = 0;

    logic [63:0] ref_mem [MW];
    logic [63:0] exp_beats [LB];
    logic [63:0] wdata [LB];
    int          lines [$];

    typedef struct {
        logic [63:0]     addr;
        int              bp;
        logic [7:0][7:0] bytes;
    } rd_vec_t;
    rd_vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic issue(input string nm, input logic [63:0] a, input logic [TW-1:0] t, output int waited);
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = a;
        bus.bus_reqtag = t;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.bus_reqack && waited < 100);
        if (!bus.bus_reqack) check({nm, "_ack_timeout"}, 64'(bus.bus_reqack), 64'd1);
        ack_cyc = cyc;
        bus.bus_reqcyc = 1'b0;
    endtask

    // Model: word index wraps modulo store size; beats walk the line from
    // the start word, wrapping inside the line.
    function automatic int line_word(input logic [63:0] addr, input int k);
        int idx;
        idx = int'((addr >> 3) % 64'(MW));
        return (idx - idx % LB) + ((idx % LB) + k) % LB;
    endfunction

    task automatic model_expect(input logic [63:0] addr);
        for (int k = 0; k < LB; k++) exp_beats[k] = ref_mem[line_word(addr, k)];
    endtask

    task automatic write_line(input string nm, input logic [63:0] addr);
        int w, a0, r0;
        idle(1);
        a0 = ack_pulses;
        r0 = resp_beats;
        issue(nm, addr, TAG_WR, w);
        check({nm, "_busy_wr"}, 64'(busy), 64'd1);
        for (int k = 0; k < LB; k++) begin
            issue(nm, wdata[k], '0, w);
            check({nm, "_beat_spacing"}, 64'(w), 64'd2);
            ref_mem[line_word(addr, k)] = wdata[k];
        end
        check({nm, "_busy_done"}, 64'(busy), 64'd0);
        idle(2);
        check({nm, "_ack_count"}, 64'(ack_pulses - a0), 64'd9);
        check({nm, "_no_resp"}, 64'(resp_beats - r0), 64'd0);
    endtask

    // bp: 0 respack held 1, 1 stall 3 cycles on beat 2, 2 random.
    task automatic collect(input string nm, input int bp, input int abort_at,
                           input bit pre, input logic [63:0] pre_addr);
        int   k = 0;
        int   stall = 0;
        int   spins = 0;
        bit   seen = 0;
        bit   hold = 0;
        logic ack;
        if (bp == 0) bus.bus_respack = 1'b1;
        while (k < LB) begin
            @(negedge clk);
            if (!bus.bus_respcyc) begin
                if (seen || spins > RL + 10) begin
                    check({nm, "_respcyc"}, 64'(bus.bus_respcyc), 64'd1);
                    bus.bus_respack = 1'b0;
                    return;
                end
                spins++;
                continue;
            end
            if (!seen) begin
                seen = 1;
                check({nm, "_latency"}, 64'(cyc - ack_cyc), 64'(RL));
            end
            check({nm, "_data"}, bus.bus_resp, exp_beats[k]);
            check({nm, "_tag"}, 64'(bus.bus_resptag), 64'(TAG_RD));
            if (hold) check({nm, "_no_ack_busy"}, 64'(bus.bus_reqack), 64'd0);
            if (k == abort_at) begin
                reset = 1'b0;
                bus.bus_respack = 1'b0;
                return;
            end
            if (pre && k == 2) begin
                hold = 1;
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = pre_addr;
                bus.bus_reqtag = TAG_RD;
            end
            if (bp == 1) begin
                ack = !(k == 2 && stall < 3);
                if (!ack) stall++;
            end else if (bp == 2) begin
                ack = ($urandom_range(0, 3) != 0);
            end else begin
                ack = 1'b1;
            end
            bus.bus_respack = ack;
            if (ack) k++;
        end
        @(negedge clk);
        check({nm, "_end_respcyc"}, 64'(bus.bus_respcyc), 64'd0);
        check({nm, "_end_resp"}, bus.bus_resp, 64'd0);
        check({nm, "_end_tag"}, 64'(bus.bus_resptag), 64'd0);
        check({nm, "_end_busy"}, 64'(busy), 64'd0);
        if (hold) check({nm, "_end_no_ack"}, 64'(bus.bus_reqack), 64'd0);
        bus.bus_respack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_reqack"}, 64'(bus.bus_reqack), 64'd0);
        check({nm, "_respcyc"}, 64'(bus.bus_respcyc), 64'd0);
        check({nm, "_resp"}, bus.bus_resp, 64'd0);
        check({nm, "_resptag"}, 64'(bus.bus_resptag), 64'd0);
        check({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic set_exp(input logic [7:0][7:0] b);
        for (int k = 0; k < LB; k++) exp_beats[k] = 64'(b[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, a0;
        logic [63:0] a;

        vecs[0] = '{addr: 64'h1000, bp: 0, bytes: 64'hA7A6A5A4A3A2A1A0};
        vecs[1] = '{addr: 64'h1028, bp: 0, bytes: 64'hA4A3A2A1A0A7A6A5};
        vecs[2] = '{addr: 64'h1038, bp: 2, bytes: 64'hA6A5A4A3A2A1A0A7};
        vecs[3] = '{addr: 64'h9008, bp: 0, bytes: 64'hA0A7A6A5A4A3A2A1};
        vecs[4] = '{addr: 64'h1000, bp: 1, bytes: 64'hA7A6A5A4A3A2A1A0};

        reset = 1'b0;
        bus.bus_reqcyc  = 1'b0;
        bus.bus_req     = '0;
        bus.bus_reqtag  = '0;
        bus.bus_respack = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        idle(2);

        for (int k = 0; k < LB; k++) wdata[k] = 64'(8'hA0 + k);
        write_line("wr_plan", 64'h1000);

        for (int i = 0; i < 5; i++) begin
            set_exp(vecs[i].bytes);
            issue($sformatf("vec%0d", i), vecs[i].addr, TAG_RD, w);
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            collect($sformatf("vec%0d", i), vecs[i].bp, -1, 1'b0, '0);
        end

        set_exp(64'hA7A6A5A4A3A2A1A0);
        issue("rej_a", 64'h1000, TAG_RD, w);
        collect("rej_a", 0, -1, 1'b1, 64'h1028);
        issue("rej_b", 64'h1028, TAG_RD, w);
        check("rej_b_accept_delay", 64'(w), 64'd1);
        set_exp(64'hA4A3A2A1A0A7A6A5);
        collect("rej_b", 0, -1, 1'b0, '0);

        set_exp(64'hA7A6A5A4A3A2A1A0);
        issue("rst_mid", 64'h1000, TAG_RD, w);
        collect("rst_mid", 0, 3, 1'b0, '0);
        @(negedge clk);
        check_reset_outputs("rst_mid_out");
        reset = 1'b1;
        idle(1);
        issue("post_rst", 64'h1000, TAG_RD, w);
        collect("post_rst", 0, -1, 1'b0, '0);

        idle(1);
        a0 = ack_pulses;
        issue("unk_tag", 64'h1000, 13'h0005, w);
        check("unk_tag_busy", 64'(busy), 64'd0);
        idle(4);
        check("unk_tag_acks", 64'(ack_pulses - a0), 64'd1);
        check("unk_tag_busy_after", 64'(busy), 64'd0);
        check("unk_tag_respcyc", 64'(bus.bus_respcyc), 64'd0);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < LB; k++) wdata[k] = {$urandom, $urandom};
            a = {$urandom, $urandom};
            write_line($sformatf("rnd_wr%0d", i), a);
            lines.push_back(line_word(a, 0) - line_word(a, 0) % LB);
            a = (64'($urandom) << (3 + AW)) |
                (64'(lines[$urandom_range(0, lines.size() - 1)] + $urandom_range(0, LB - 1)) << 3) |
                64'($urandom_range(0, 7));
            model_expect(a);
            issue($sformatf("rnd_rd%0d", i), a, TAG_RD, w);
            collect($sformatf("rnd_rd%0d", i), 2, -1, 1'b0, '0);
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
